dmem_responder: RTL and testbench

- Data-memory responder that serves the load/store side of the single-cycle RISC-V core.
- Inputs: core's MemRead, MemWrite, ALUResult (used as byte address) and WriteData.
- Outputs: ReadData and the stall that freezes the core while an access is in flight.
- Word-organised RAM behind a fixed, parameterised wait-state FSM; one access outstanding at a time.

---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM behind a fixed wait-state FSM.
// Holds stall for WAIT_CYCLES cycles per access, then one DONE cycle with ack and load data.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        ack,
    output logic        misalign
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 1 ? WAIT_CYCLES - 1 : 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] word;
    logic              req;
    logic              wr_en;
    logic              blk_q;
    logic              unused_addr;

    assign word        = Addr[ADDR_W+1:2];
    assign req         = MemRead | MemWrite;
    assign unused_addr = ^{Addr[31:ADDR_W+2]};

    // Outputs and request acceptance are masked in the cycle following reset.
    always_ff @(posedge clk) begin
        blk_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word] <= WriteData;
        end
    end

    generate
        if (WAIT_CYCLES == 0) begin : g_zero
            assign stall    = 1'b0;
            assign ack      = req & ~blk_q;
            assign misalign = ack & (|Addr[1:0]);
            assign ReadData = (MemRead & ~MemWrite & ~blk_q) ? mem_q[word] : 32'h0;
            assign wr_en    = MemWrite & ~rst & ~blk_q;
        end else begin : g_fsm
            state_t      state_q, state_d;
            logic [3:0]  cnt_q, cnt_d;
            logic [31:0] rd_q, rd_d;
            logic        req_v;

            assign req_v    = req & ~blk_q;
            assign misalign = ack & (|Addr[1:0]);

            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                rd_d     = rd_q;
                stall    = 1'b0;
                ack      = 1'b0;
                ReadData = 32'h0;
                wr_en    = 1'b0;
                case (state_q)
                    S_IDLE: begin
                        stall = req_v;
                        if (req_v) begin
                            if (WAIT_CYCLES == 1) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_WAIT;
                                cnt_d   = CNT_INIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        stall = req_v;
                        if (!req_v) begin
                            state_d = S_IDLE;
                        end else if (cnt_q == 4'd1) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = 4'(cnt_q - 4'd1);
                        end
                    end
                    S_DONE: begin
                        ack      = 1'b1;
                        ReadData = rd_q;
                        wr_en    = MemWrite & ~rst;
                        state_d  = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
                // A combined read/write is a write, so its load data reads back as zero.
                if (state_d == S_DONE && state_q != S_DONE) begin
                    rd_d = MemWrite ? 32'h0 : mem_q[word];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                    rd_q    <= 32'h0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    rd_q    <= rd_d;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 3 wait cycles) driven by directed
// and random accesses, checked against a word-array memory model and the stall/ack timing rule.
module tb_dmem_responder;
    localparam int AW = 10;

    logic        clk;
    logic        rst;
    logic        mr [3];
    logic        mw [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [31:0] rdv [3];
    logic        st [3];
    logic        ak [3];
    logic        ma [3];

    int          total;
    int          bad;
    int          cyc;
    int          last_ack;
    logic [31:0] ref_mem [3][1 << AW];
    int          wq [3][$];

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .Addr(ad[0]),
        .WriteData(wd[0]), .ReadData(rdv[0]), .stall(st[0]), .ack(ak[0]), .misalign(ma[0]));
    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .Addr(ad[1]),
        .WriteData(wd[1]), .ReadData(rdv[1]), .stall(st[1]), .ack(ak[1]), .misalign(ma[1]));
    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .MemRead(mr[2]), .MemWrite(mw[2]), .Addr(ad[2]),
        .WriteData(wd[2]), .ReadData(rdv[2]), .stall(st[2]), .ack(ak[2]), .misalign(ma[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic int wcyc(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 after the DONE cycle with inputs dropped.
    task automatic access(input int k, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] exp_rd;
        int          idx;
        idx    = int'(a[AW+1:2]);
        exp_rd = (r && !w) ? ref_mem[k][idx] : 32'h0;
        mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
        for (int c = 0; c < wcyc(k); c++) begin
            @(negedge clk);
            chk({tag, ".stall"}, 32'(st[k]), 32'd1);
            chk({tag, ".ack_early"}, 32'(ak[k]), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, ".stall_done"}, 32'(st[k]), 32'd0);
        chk({tag, ".ack"}, 32'(ak[k]), 32'd1);
        chk({tag, ".misalign"}, 32'(ma[k]), 32'(a[1:0] != 2'b00));
        chk({tag, ".rdata"}, rdv[k], exp_rd);
        last_ack = cyc;
        @(posedge clk); #1;
        if (w) begin
            ref_mem[k][idx] = d;
            wq[k].push_back(idx);
        end
        mr[k] = 1'b0; mw[k] = 1'b0;
    endtask

    initial begin
        int a1;
        total = 0; bad = 0; cyc = 0; last_ack = 0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mr[k] = 1'b1; mw[k] = 1'b0; ad[k] = 32'h3; wd[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst.stall", 32'(st[k]), 32'd0);
            chk("rst.ack", 32'(ak[k]), 32'd0);
            chk("rst.misalign", 32'(ma[k]), 32'd0);
            chk("rst.rdata", rdv[k], 32'h0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) mr[k] = 1'b0;
        @(posedge clk); #1;

        // store then load
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "t1.st");
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, "t1.ld");

        // back-to-back store/load with ack spacing
        access(0, 1'b0, 1'b1, 32'h20, 32'h11111111, "t2.st");
        a1 = last_ack;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, "t2.ld");
        chk("t2.ack_gap", 32'(last_ack - a1), 32'd3);

        // address aliasing and misalignment
        access(0, 1'b0, 1'b1, 32'h1010, 32'hCAFEF00D, "t3.st");
        access(0, 1'b1, 1'b0, 32'h0010, 32'h0, "t3.ld");
        chk("t3.alias", ref_mem[0][4], 32'hCAFEF00D);
        access(0, 1'b1, 1'b0, 32'h0013, 32'h0, "t3.mis");

        // reset during the WAIT cycle drops a pending store
        access(0, 1'b0, 1'b1, 32'h30, 32'h12345678, "t4.pre");
        mw[0] = 1'b1; ad[0] = 32'h30; wd[0] = 32'h55555555;
        @(negedge clk);
        chk("t4.stall_idle", 32'(st[0]), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t4.stall_wait", 32'(st[0]), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t4.stall_after", 32'(st[0]), 32'd0);
        chk("t4.ack_after", 32'(ak[0]), 32'd0);
        @(posedge clk); #1 mw[0] = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, "t4.ld");

        // zero-wait path
        access(1, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, "t5.st");
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, "t5.ld");

        // read+write together is a write
        access(2, 1'b1, 1'b1, 32'h50, 32'h0F0F0F0F, "t6.rw");
        access(2, 1'b1, 1'b0, 32'h50, 32'h0, "t6.ld");

        // random traffic
        for (int n = 0; n < 150; n++) begin
            int          k;
            int          op;
            int          gap;
            logic [31:0] a;
            logic [31:0] d;
            k  = int'($urandom_range(0, 2));
            op = int'($urandom_range(0, 2));
            a  = $urandom;
            d  = $urandom;
            if (op == 0 && wq[k].size() == 0) op = 1;
            if (op == 0) begin
                a[AW+1:2] = AW'(wq[k][$urandom_range(0, wq[k].size() - 1)]);
            end
            access(k, op != 1, op != 0, a, d, "rnd");
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
